// File: rtl/u_game_judge.sv
// u_game_judge: grades a synchronized player press against a note timing window (Perfect/Normal/Miss).
// Optional debounce on the button path is enabled by defining U_GAME_JUDGE_DEBOUNCE_EN.
module u_game_judge #(
  parameter logic [23:0] WIN_LEN  = 24'd5_000_000,
  parameter logic [23:0] PERF_TOL = 24'd1_000_000,
  parameter logic [23:0] HOLD_CYC = 24'd2_500_000,
  parameter logic [19:0] DEB_CYC  = 20'd500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn,
  input  logic       i_note,
  output logic [1:0] o_judge,
  output logic       o_busy,
  output logic       o_press,
  output logic [7:0] o_drop_cnt
);
  typedef enum logic [1:0] {IDLE, WINDOW, REPORT, GAP} state_t;
  state_t      r_state;
  logic [1:0]  r_sync, r_fill;
  logic        r_prev, r_arm, w_lvl;
  logic [23:0] r_t, r_hold, w_half, w_d;
`ifdef U_GAME_JUDGE_DEBOUNCE_EN
  logic        r_deb;
  logic [19:0] r_dcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_deb  <= 1'b0;
      r_dcnt <= '0;
    end else if (r_sync[1] == r_deb)
      r_dcnt <= '0;
    else if (r_dcnt == DEB_CYC - 20'd1) begin
      r_deb  <= r_sync[1];
      r_dcnt <= '0;
    end else
      r_dcnt <= r_dcnt + 20'd1;
  assign w_lvl = r_deb;
`else
  assign w_lvl = r_sync[1];
`endif
  // r_arm stays low until the settled synchronizer has seen the button released, so a held button at reset never presses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_arm   <= 1'b0;
      r_prev  <= 1'b0;
      o_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_fill  <= {r_fill[0], 1'b1};
      r_arm   <= r_arm | (r_fill[1] & ~r_sync[1]);
      r_prev  <= w_lvl;
      o_press <= w_lvl & ~r_prev & r_arm;
    end
  assign w_half = WIN_LEN >> 1;
  assign w_d    = (r_t >= w_half) ? r_t - w_half : w_half - r_t;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_t        <= '0;
      r_hold     <= '0;
      o_judge    <= 2'b00;
      o_busy     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (r_state != IDLE && i_note && o_drop_cnt != 8'hff)
        o_drop_cnt <= o_drop_cnt + 8'd1;
      case (r_state)
        IDLE:
          if (i_note) begin
            r_state <= WINDOW;
            r_t     <= '0;
            o_busy  <= 1'b1;
          end
        WINDOW:
          if (o_press || r_t == WIN_LEN - 24'd1) begin
            r_state <= REPORT;
            r_hold  <= '0;
            o_judge <= !o_press ? 2'b01 : (w_d <= PERF_TOL) ? 2'b11 : 2'b10;
          end else
            r_t <= r_t + 24'd1;
        REPORT:
          if (r_hold == HOLD_CYC - 24'd1) begin
            r_state <= GAP;
            o_judge <= 2'b00;
          end else
            r_hold <= r_hold + 24'd1;
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_u_game_judge.sv
// tb_u_game_judge: directed checks of u_game_judge with WIN_LEN=20, PERF_TOL=2, HOLD_CYC=4, DEB_CYC=3.
module tb_u_game_judge;
  localparam int WIN = 20, HOLD = 4;
`ifdef U_GAME_JUDGE_DEBOUNCE_EN
  localparam int LAT = 6, GLITCH_EXP = 0;
`else
  localparam int LAT = 3, GLITCH_EXP = 1;
`endif
  logic       clk = 1'b0, rst = 1'b1, i_btn = 1'b0, i_note = 1'b0;
  logic [1:0] o_judge;
  logic       o_busy, o_press;
  logic [7:0] o_drop_cnt;
  int         checks = 0, errors = 0, np;

  u_game_judge #(.WIN_LEN(24'd20), .PERF_TOL(24'd2), .HOLD_CYC(24'd4), .DEB_CYC(20'd3)) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_note(i_note),
    .o_judge(o_judge), .o_busy(o_busy), .o_press(o_press), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // t_press < 0 means no press (window expires); drop injects an i_note during REPORT
  task automatic run_note(input int t_press, input logic [1:0] exp, input bit drop, input string tag);
    int last;
    last = (t_press < 0) ? WIN - 1 : t_press;
    for (int k = -LAT; k <= last; k++) begin
      i_note = (k == 0);
      i_btn  = (t_press >= 0) && (k >= t_press - LAT + 1);
      step();
    end
    i_note = 1'b0;
    if (t_press >= 0) chk({tag, "_press"}, 32'(o_press), 1);
    else chk({tag, "_pre"}, 32'(o_judge), 0);
    chk({tag, "_busyw"}, 32'(o_busy), 1);
    i_btn = 1'b0;
    for (int h = 0; h < HOLD; h++) begin
      step();
      i_note = drop && (h == 1);
      chk({tag, "_judge"}, 32'(o_judge), 32'(exp));
      chk({tag, "_busyr"}, 32'(o_busy), 1);
    end
    i_note = 1'b0;
    step();
    chk({tag, "_gap"}, 32'(o_judge), 0);
    chk({tag, "_busyg"}, 32'(o_busy), 1);
    step();
    chk({tag, "_idle"}, 32'(o_busy), 0);
    chk({tag, "_idlej"}, 32'(o_judge), 0);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_judge", 32'(o_judge), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_press", 32'(o_press), 0);
    chk("rst_drop", 32'(o_drop_cnt), 0);
    rst = 1'b0;
    repeat (5) step();
    run_note(11, 2'b11, 1'b0, "centre");
    run_note(3, 2'b10, 1'b0, "early");
    run_note(12, 2'b11, 1'b0, "edge_perf");
    run_note(-1, 2'b01, 1'b0, "expire");
    chk("drop_none", 32'(o_drop_cnt), 0);
    run_note(19, 2'b10, 1'b1, "collide");
    chk("drop_one", 32'(o_drop_cnt), 1);
    repeat (3) begin
      step();
      chk("drop_nowin", 32'(o_busy), 0);
    end
    run_note(3, 2'b10, 1'b0, "normal_a");
    run_note(16, 2'b10, 1'b0, "normal_b");
    i_note = 1'b1;
    step();
    i_note = 1'b0;
    repeat (5) step();
    chk("mid_busy", 32'(o_busy), 1);
    i_btn = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst_judge", 32'(o_judge), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_press", 32'(o_press), 0);
    chk("mrst_drop", 32'(o_drop_cnt), 0);
    step();
    rst = 1'b0;
    np = 0;
    repeat (12) begin
      step();
      np += int'(o_press);
      chk("held_judge", 32'(o_judge), 0);
    end
    chk("held_nopress", 32'(np), 0);
    i_btn = 1'b0;
    repeat (LAT + 2) step();
    i_btn = 1'b1;
    np = 0;
    repeat (LAT + 4) begin
      step();
      np += int'(o_press);
      chk("free_judge", 32'(o_judge), 0);
      chk("free_busy", 32'(o_busy), 0);
    end
    chk("free_press", 32'(np), 1);
    i_btn = 1'b0;
    repeat (10) step();
    i_btn = 1'b1;
    repeat (2) step();
    i_btn = 1'b0;
    np = 0;
    repeat (12) begin
      step();
      np += int'(o_press);
    end
    chk("glitch", 32'(np), 32'(GLITCH_EXP));
    i_btn = 1'b1;
    np = 0;
    repeat (5) begin
      step();
      np += int'(o_press);
    end
    i_btn = 1'b0;
    repeat (12) begin
      step();
      np += int'(o_press);
    end
    chk("pulse5", 32'(np), 1);
    chk("end_judge", 32'(o_judge), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
